// File: rtl/kore_funcfsm_if.sv
// kore_funcfsm_if: operation request, register-file and completion signals of the functional-unit FSM
interface kore_funcfsm_if #(parameter int DW = 32, parameter int AW = 5);
  logic          opflag;
  logic [6:0]    opcode;
  logic [AW-1:0] pcdata_rs0;
  logic [AW-1:0] pcdata_rs1;
  logic [AW-1:0] pcdata_rd;
  logic [2:0]    pcdata_bc;
  logic          rf_ren;
  logic [AW-1:0] rf_raddr0;
  logic [AW-1:0] rf_raddr1;
  logic [DW-1:0] rf_rdata0;
  logic [DW-1:0] rf_rdata1;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          eop;
  logic          bc_taken;
  logic          op_err;
  logic          busy;
  modport master (
    output opflag, opcode, pcdata_rs0, pcdata_rs1, pcdata_rd, pcdata_bc, rf_rdata0, rf_rdata1,
    input  rf_ren, rf_raddr0, rf_raddr1, rf_wen, rf_waddr, rf_wdata, eop, bc_taken, op_err, busy
  );
  modport slave (
    input  opflag, opcode, pcdata_rs0, pcdata_rs1, pcdata_rd, pcdata_bc, rf_rdata0, rf_rdata1,
    output rf_ren, rf_raddr0, rf_raddr1, rf_wen, rf_waddr, rf_wdata, eop, bc_taken, op_err, busy
  );
endinterface

// File: rtl/kore_funcfsm.sv
// kore_funcfsm: read-execute-writeback FSM for ALU and branch-compare ops; KORE_FUNC_MUL_EN adds a two-cycle multiply
module kore_funcfsm #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic          clk,
  input logic          rst,
  kore_funcfsm_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_CLR  = 3'd5;
  logic [2:0]    r_state;
  logic [6:0]    r_opcode;
  logic [AW-1:0] r_rs0;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rd;
  logic [2:0]    r_bc;
  logic [DW-1:0] r_res;
  logic          r_taken;
  logic          w_alu;
  logic          w_br;
  logic          w_mul;
  logic          w_legal;
  logic          w_wr;
  logic [4:0]    w_sh;
  logic [DW-1:0] w_alu_res;
`ifdef KORE_FUNC_MUL_EN
  logic          r_mwait;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  assign w_mul = r_opcode == 7'h3B && r_bc == 3'd0;
`else
  assign w_mul = 1'b0;
`endif
  assign w_alu     = r_opcode == 7'h33 && r_bc != 3'd7;
  assign w_br      = r_opcode == 7'h33 && r_bc == 3'd7;
  assign w_legal   = w_alu || w_br || w_mul;
  assign w_wr      = (w_alu || w_mul) && r_rd != '0;
  assign w_sh      = bus.rf_rdata1[4:0];
  assign w_alu_res = r_bc == 3'd0 ? bus.rf_rdata0 + bus.rf_rdata1 :
                     r_bc == 3'd1 ? bus.rf_rdata0 - bus.rf_rdata1 :
                     r_bc == 3'd2 ? bus.rf_rdata0 & bus.rf_rdata1 :
                     r_bc == 3'd3 ? bus.rf_rdata0 | bus.rf_rdata1 :
                     r_bc == 3'd4 ? bus.rf_rdata0 ^ bus.rf_rdata1 :
                     r_bc == 3'd5 ? bus.rf_rdata0 << w_sh :
                                    bus.rf_rdata0 >> w_sh;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.rf_ren    = r_state == S_RD;
  assign bus.rf_raddr0 = bus.rf_ren ? r_rs0 : '0;
  assign bus.rf_raddr1 = bus.rf_ren ? r_rs1 : '0;
  assign bus.rf_wen    = r_state == S_WB && w_wr;
  assign bus.rf_waddr  = bus.rf_wen ? r_rd : '0;
  assign bus.rf_wdata  = bus.rf_wen ? r_res : '0;
  assign bus.eop       = r_state == S_DONE;
  assign bus.bc_taken  = bus.eop && w_br && r_taken;
  assign bus.op_err    = bus.eop && !w_legal;
  // Sequencing: one pass IDLE-RD-EXEC-WB-DONE, then CLR blocks re-entry until the request is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  r_state <= bus.opflag ? S_RD : S_IDLE;
        S_RD:    r_state <= S_EXEC;
`ifdef KORE_FUNC_MUL_EN
        S_EXEC:  r_state <= (w_mul && !r_mwait) ? S_EXEC : S_WB;
`else
        S_EXEC:  r_state <= S_WB;
`endif
        S_WB:    r_state <= S_DONE;
        S_DONE:  r_state <= S_CLR;
        S_CLR:   r_state <= bus.opflag ? S_CLR : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // Operation fields are frozen at acceptance; operands are consumed in the first EXEC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= '0;
      r_rs0    <= '0;
      r_rs1    <= '0;
      r_rd     <= '0;
      r_bc     <= '0;
      r_res    <= '0;
      r_taken  <= 1'b0;
`ifdef KORE_FUNC_MUL_EN
      r_mwait  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && bus.opflag) begin
        r_opcode <= bus.opcode;
        r_rs0    <= bus.pcdata_rs0;
        r_rs1    <= bus.pcdata_rs1;
        r_rd     <= bus.pcdata_rd;
        r_bc     <= bus.pcdata_bc;
      end
      if (r_state == S_EXEC) begin
`ifdef KORE_FUNC_MUL_EN
        r_mwait <= w_mul && !r_mwait;
        if (r_mwait) r_res <= r_a * r_b;
        else begin
          r_res   <= w_alu_res;
          r_taken <= bus.rf_rdata0 == bus.rf_rdata1;
          r_a     <= bus.rf_rdata0;
          r_b     <= bus.rf_rdata1;
        end
`else
        r_res   <= w_alu_res;
        r_taken <= bus.rf_rdata0 == bus.rf_rdata1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_kore_funcfsm.sv
// tb_kore_funcfsm: randomized scoreboard bench for kore_funcfsm (honours KORE_FUNC_MUL_EN like the design)
module tb_kore_funcfsm;
  localparam int DW = 32;
  localparam int AW = 5;
  typedef struct {
    logic          wen;
    logic [AW-1:0] ra0, ra1, waddr;
    logic [DW-1:0] wdata;
    logic          taken, err;
    int            lat, acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  kore_funcfsm_if #(.DW(DW), .AW(AW)) bus();
  kore_funcfsm #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t          q[$];
  exp_t          me;
  logic [DW-1:0] rf[32];
  int            checks = 0, errors = 0, cyc = 0, nw = 0, age = 0, neop = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic miss(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask
  function automatic exp_t model(logic [6:0] op, logic [2:0] bc, logic [AW-1:0] s0, logic [AW-1:0] s1, logic [AW-1:0] d);
    exp_t e;
    logic [DW-1:0] a, b;
    a = rf[s0];
    b = rf[s1];
    e.ra0 = s0; e.ra1 = s1; e.waddr = d; e.wen = 1'b0; e.wdata = '0;
    e.taken = 1'b0; e.err = 1'b0; e.lat = 4; e.acc = 0;
    if (op == 7'h33 && bc == 3'd7) e.taken = (a == b);
    else if (op == 7'h33) begin
      e.wen = (d != 0);
      case (bc)
        3'd0: e.wdata = a + b;
        3'd1: e.wdata = a - b;
        3'd2: e.wdata = a & b;
        3'd3: e.wdata = a | b;
        3'd4: e.wdata = a ^ b;
        3'd5: e.wdata = a << (b % 32);
        default: e.wdata = a >> (b % 32);
      endcase
    end
`ifdef KORE_FUNC_MUL_EN
    else if (op == 7'h3B && bc == 3'd0) begin
      e.wen = (d != 0);
      e.wdata = DW'((64'(a) * 64'(b)) % 64'h1_0000_0000);
      e.lat = 5;
    end
`endif
    else e.err = 1'b1;
    return e;
  endfunction
  // register-file responder: data valid from the cycle after rf_ren, then garbage
  always @(negedge clk) begin
    if (bus.rf_ren) begin
      bus.rf_rdata0 = rf[bus.rf_raddr0];
      bus.rf_rdata1 = rf[bus.rf_raddr1];
      age = 1;
    end else if (age == 1) age = 2;
    else if (age == 2) begin
      bus.rf_rdata0 = $urandom;
      bus.rf_rdata1 = $urandom;
      age = 0;
    end
  end
  // monitor: pops the scoreboard on every eop
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      nw = 0;
    end else begin
      if (bus.rf_ren || bus.rf_wen || bus.eop)
        chk("strobe_excl", int'(bus.rf_ren) + int'(bus.rf_wen) + int'(bus.eop), 1);
      if (bus.rf_ren) begin
        if (q.size() == 0) miss("spurious_ren", "rf_ren seen, none expected");
        else begin
          chk("raddr0", bus.rf_raddr0, q[0].ra0);
          chk("raddr1", bus.rf_raddr1, q[0].ra1);
        end
      end
      if (bus.rf_wen) begin
        if (q.size() == 0) miss("spurious_wen", "rf_wen seen, none expected");
        else begin
          nw++;
          chk("waddr", bus.rf_waddr, q[0].waddr);
          chk("wdata", bus.rf_wdata, q[0].wdata);
        end
      end
      if (bus.eop) begin
        neop++;
        if (q.size() == 0) miss("spurious_eop", "eop seen, none expected");
        else begin
          me = q.pop_front();
          chk("wen_count", nw, int'(me.wen));
          chk("bc_taken", bus.bc_taken, me.taken);
          chk("op_err", bus.op_err, me.err);
          chk("latency", cyc - me.acc + 1, me.lat);
        end
        nw = 0;
      end
    end
  end
  task automatic run_op(logic [6:0] op, logic [2:0] bc, logic [AW-1:0] s0, logic [AW-1:0] s1, logic [AW-1:0] d, int hold, bit drop);
    int n, n0;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      miss("idle_timeout", "busy still high after 20 cycles, expected idle");
      return;
    end
    n0 = neop;
    bus.opflag = 1'b1;
    bus.opcode = op;
    bus.pcdata_bc = bc;
    bus.pcdata_rs0 = s0;
    bus.pcdata_rs1 = s1;
    bus.pcdata_rd = d;
    e = model(op, bc, s0, s1, d);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.opcode = 7'($urandom);
    bus.pcdata_bc = 3'($urandom);
    bus.pcdata_rs0 = AW'($urandom);
    bus.pcdata_rs1 = AW'($urandom);
    bus.pcdata_rd = AW'($urandom);
    if (drop) bus.opflag = 1'b0;
    n = 0;
    while (!bus.eop && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.eop) miss("eop_timeout", "no eop within 20 cycles, expected one");
    repeat (hold) @(negedge clk);
    bus.opflag = 1'b0;
    repeat (2) @(negedge clk);
    chk("eop_count", neop - n0, 1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic [6:0] op;
    logic [2:0] bc;
    logic [AW-1:0] s0, s1, d;
    int n0;
    bus.opflag = 1'b0;
    bus.opcode = '0;
    bus.pcdata_bc = '0;
    bus.pcdata_rs0 = '0;
    bus.pcdata_rs1 = '0;
    bus.pcdata_rd = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.busy, bus.eop, bus.rf_ren, bus.rf_wen, bus.bc_taken, bus.op_err,
                       bus.rf_raddr0, bus.rf_raddr1, bus.rf_waddr, bus.rf_wdata}, 64'd0);
    rst = 1'b0;
    rf[1] = 32'h7; rf[2] = 32'h5;
    run_op(7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 0, 1'b0);
    rf[4] = 32'h0; rf[5] = 32'h1;
    run_op(7'h33, 3'd1, 5'd4, 5'd5, 5'd6, 1, 1'b0);
    run_op(7'h33, 3'd1, 5'd4, 5'd5, 5'd0, 0, 1'b1);
    rf[7] = 32'hA5A5A5A5; rf[8] = 32'hA5A5A5A5;
    run_op(7'h33, 3'd7, 5'd7, 5'd8, 5'd9, 0, 1'b0);
    rf[8] = 32'h5A5A5A5A;
    run_op(7'h33, 3'd7, 5'd7, 5'd8, 5'd9, 0, 1'b0);
    run_op(7'h13, 3'd0, 5'd1, 5'd2, 5'd3, 10, 1'b0);
    rf[9] = 32'h10000; rf[10] = 32'h10001;
    run_op(7'h3B, 3'd0, 5'd9, 5'd10, 5'd11, 0, 1'b0);
    @(negedge clk);
    bus.opflag = 1'b1;
    bus.opcode = 7'h33;
    bus.pcdata_bc = 3'd0;
    bus.pcdata_rs0 = 5'd1;
    bus.pcdata_rs1 = 5'd2;
    bus.pcdata_rd = 5'd12;
    me = model(7'h33, 3'd0, 5'd1, 5'd2, 5'd12);
    me.acc = cyc + 1;
    q.push_back(me);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.opflag = 1'b0;
    #1;
    chk("rst_exec_outs", {bus.busy, bus.eop, bus.rf_wen}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = neop;
    repeat (8) @(negedge clk);
    chk("rst_no_eop", neop - n0, 0);
    chk("rst_idle", bus.busy, 1'b0);
    run_op(7'h33, 3'd4, 5'd1, 5'd2, 5'd12, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      s0 = AW'($urandom);
      s1 = AW'($urandom);
      d = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
      rf[s0] = $urandom;
      rf[s1] = ($urandom_range(0, 3) == 0) ? rf[s0] : $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: op = 7'h33;
        6, 7:             op = 7'h3B;
        8:                op = 7'h13;
        default:          op = 7'($urandom);
      endcase
      bc = 3'($urandom);
      if (op == 7'h3B && $urandom_range(0, 1) == 1) bc = 3'd0;
      run_op(op, bc, s0, s1, d, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kore_funcfsm.md
KORE_FUNCFSM -- requirements
Module: kore_funcfsm

Interface
REQ-001 Parameter: DW, 32, operand/result data width; shift amounts use operand bits [4:0].
REQ-002 Parameter: AW, 5, register-file address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 opflag  in  1  level operation request from the op FSM; held high until eop is seen.
REQ-006 opcode  in  7  major opcode, sampled on request acceptance.
REQ-007 pcdata_rs0 / pcdata_rs1 / pcdata_rd  in  AW each  source-0, source-1, destination register indices.
REQ-008 pcdata_bc  in  3  function select (funct3).
REQ-009 rf_ren  out  1  register-file read strobe; rf_raddr0/rf_raddr1 out AW each are the read addresses.
REQ-010 rf_rdata0 / rf_rdata1  in  DW each  read data, valid exactly one cycle after rf_ren.
REQ-011 rf_wen  out  1; rf_waddr  out  AW; rf_wdata  out  DW  single-cycle write-back port.
REQ-012 eop  out  1  end-of-operation pulse, one cycle wide.
REQ-013 bc_taken  out  1  branch-compare result, valid while eop=1.
REQ-014 op_err  out  1  illegal-operation flag, valid while eop=1.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, RD, EXEC, WB, DONE, CLR; encoding is free.
REQ-017 IDLE->RD when opflag=1; opcode, rs0, rs1, rd, bc SHALL be latched on that edge and held for the whole operation.
REQ-018 RD: rf_ren=1 for one cycle with rf_raddr0=latched rs0 and rf_raddr1=latched rs1; RD->EXEC unconditionally.
REQ-019 EXEC: capture rf_rdata0/1 and compute the result into a DW-bit register; EXEC->WB.
REQ-020 For opcode 7'h33: bc 000 ADD, 001 SUB (rs0-rs1), 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL (logical), all modulo 2^DW with carries discarded.
REQ-021 For opcode 7'h33 with bc 111: branch compare; bc_taken=(rs0==rs1); no write-back.
REQ-022 Any other opcode/bc combination SHALL be illegal: op_err=1 at eop, no write-back, bc_taken=0.
REQ-023 WB: rf_wen=1 for one cycle with rf_waddr=latched rd and rf_wdata=result, only for legal ALU ops with rd!=0; WB->DONE.
REQ-024 DONE: eop=1 for exactly one cycle; DONE->CLR.
REQ-025 CLR: wait until opflag=0, then ->IDLE; a request still high after eop SHALL NOT start a second operation.
REQ-026 Latency: acceptance edge to eop high SHALL be 4 cycles (RD, EXEC, WB, DONE) for every op.
REQ-027 opflag dropping before eop SHALL NOT abort the operation; it completes and eop still pulses.
REQ-028 Input field changes after acceptance SHALL have no effect on the current operation.
REQ-029 rf_ren, rf_wen and eop SHALL never be high in the same cycle.

Reset
REQ-030 While rst=1: state=IDLE; eop, rf_ren, rf_wen, bc_taken, op_err and busy =0; rf_raddr0/1, rf_waddr and rf_wdata =0.
REQ-031 Reset asserted mid-operation SHALL abandon it with no further write and no eop; after release the block waits in IDLE for opflag=1.

Configuration
REQ-032 Macro KORE_FUNC_MUL_EN defined: opcode 7'h3B with bc 000 SHALL compute the low DW bits of rs0*rs1 (unsigned), adding one extra EXEC cycle, so latency is 5 cycles.
REQ-033 KORE_FUNC_MUL_EN undefined: opcode 7'h3B SHALL be illegal per REQ-022 and the multiplier SHALL not be synthesized.

Verification
REQ-034 ADD: rs0=1 (32'h7), rs1=2 (32'h5), rd=3, opcode 7'h33, bc 000 -> rf_wen with waddr 3, wdata 32'hC; eop 4 cycles after acceptance.
REQ-035 SUB wrap: rs0=32'h0, rs1=32'h1, bc 001 -> wdata 32'hFFFFFFFF; rd=0 variant -> rf_wen never asserted, eop still pulses.
REQ-036 Branch compare: bc 111, both operands 32'hA5A5A5A5 -> bc_taken=1 at eop, no rf_wen; operands differ -> bc_taken=0.
REQ-037 Illegal: opcode 7'h13 -> op_err=1 at eop, no rf_wen; opflag held high 10 cycles after eop -> exactly one eop.
REQ-038 Reset in EXEC -> no rf_wen, no eop, busy=0; next request executes normally.
REQ-039 KORE_FUNC_MUL_EN defined: opcode 7'h3B, 32'h10000 x 32'h10001 -> wdata 32'h00010000 after 5-cycle latency; undefined -> op_err=1.
